// File: rtl/sine_capture_checker_if.sv
// sine_capture_checker_if: stream, table-lookup and status bundle for the sine capture checker
interface sine_capture_checker_if;
    logic        start;
    logic        din_valid;
    logic [15:0] din_re;
    logic [5:0]  exp_addr;
    logic [15:0] exp_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [6:0]  err_cnt;
    logic [16:0] max_err;
    logic [5:0]  first_err_idx;
    modport master (
        output start, din_valid, din_re, exp_data,
        input  exp_addr, busy, done, pass, timed_out, err_cnt, max_err, first_err_idx
    );
    modport slave (
        input  start, din_valid, din_re, exp_data,
        output exp_addr, busy, done, pass, timed_out, err_cnt, max_err, first_err_idx
    );
endinterface

// File: rtl/sine_capture_checker.sv
// sine_capture_checker: compares a 64-sample Q15 stream against a sine table within a tolerance
module sine_capture_checker #(
    parameter logic [15:0] TOL     = 16'd4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sine_capture_checker_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
    logic [1:0]  r_state;
    logic [5:0]  r_idx;
    logic [6:0]  r_err_cnt;
    logic [16:0] r_max_err;
    logic [5:0]  r_first;
    logic        r_pass;
    logic        r_tout;
    logic [31:0] r_idle;
    logic [16:0] w_diff;
    logic [16:0] w_absd;
    logic        w_bad;
    logic        w_acc;
    // 17-bit difference cannot overflow; its magnitude tops out at 65535
    assign w_diff = {bus.din_re[15], bus.din_re} - {bus.exp_data[15], bus.exp_data};
    assign w_absd = w_diff[16] ? -w_diff : w_diff;
    assign w_bad  = w_absd > {1'b0, TOL};
    assign w_acc  = (r_state == S_RUN) && bus.din_valid;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_err_cnt <= '0;
            r_max_err <= '0;
            r_first   <= '0;
            r_pass    <= 1'b0;
            r_tout    <= 1'b0;
            r_idle    <= '0;
        end else if (r_state != S_RUN && bus.start) begin
            r_state   <= S_RUN;
            r_idx     <= '0;
            r_err_cnt <= '0;
            r_max_err <= '0;
            r_first   <= '0;
            r_pass    <= 1'b0;
            r_tout    <= 1'b0;
            r_idle    <= '0;
        end else if (w_acc) begin
            r_idx  <= r_idx + 6'd1;
            r_idle <= '0;
            if (w_absd > r_max_err) r_max_err <= w_absd;
            if (w_bad) begin
                r_err_cnt <= r_err_cnt + 7'd1;
                if (r_err_cnt == 7'd0) r_first <= r_idx;
            end
            if (r_idx == 6'd63) begin
                r_state <= S_DONE;
                r_pass  <= (r_err_cnt == 7'd0) && !w_bad;
            end
        end else if (r_state == S_RUN) begin
            if (TIMEOUT != 0 && r_idle == TIMEOUT) begin
                r_state <= S_DONE;
                r_tout  <= 1'b1;
                r_pass  <= 1'b0;
            end else begin
                r_idle <= r_idle + 32'd1;
            end
        end
    end
    assign bus.exp_addr      = r_idx;
    assign bus.busy          = r_state == S_RUN;
    assign bus.done          = r_state == S_DONE;
    assign bus.pass          = r_pass;
    assign bus.timed_out     = r_tout;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.max_err       = r_max_err;
    assign bus.first_err_idx = r_first;
endmodule

// File: tb/tb_sine_capture_checker.sv
// tb_sine_capture_checker: two checkers (TIMEOUT 1024 and 16) on one stimulus, checked against a capture model
module tb_sine_capture_checker;
    localparam int TOL = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] din = '0;
    logic        go = 1'b0;
    logic [15:0] tbl [64];
    int checks = 0;
    int errors = 0;
    sine_capture_checker_if ia ();
    sine_capture_checker_if ib ();
    assign ia.start = start;
    assign ib.start = start;
    assign ia.din_valid = valid;
    assign ib.din_valid = valid;
    assign ia.din_re = din;
    assign ib.din_re = din;
    assign ia.exp_data = tbl[ia.exp_addr];
    assign ib.exp_data = tbl[ib.exp_addr];
    sine_capture_checker #(.TOL(16'd4), .TIMEOUT(1024)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ia));
    sine_capture_checker #(.TOL(16'd4), .TIMEOUT(16))   dut_b (.i_clk(clk), .i_rst(rst), .bus(ib));
    always #5 clk = ~clk;
    initial begin
        for (int k = 0; k < 64; k++) begin
            int v;
            v = $rtoi(32768.0 * $sin(2.0 * 3.14159265358979 * k / 64.0));
            if (v > 32767) v = 32767;
            if (v < -32767) v = -32767;
            tbl[k] = v[15:0];
        end
    end
    // Model: a capture is the list of |error| values per accepted index
    int tmo [2] = '{1024, 16};
    int m_ph [2];
    int m_n [2];
    int m_last [2];
    int m_to [2];
    int m_pass [2];
    int m_abs [2][64];
    int cyc = 0;
    function automatic int m_errs(input int d);
        int c = 0;
        for (int i = 0; i < m_n[d] && i < 64; i++) if (m_abs[d][i] > TOL) c++;
        return c;
    endfunction
    function automatic int m_max(input int d);
        int m = 0;
        for (int i = 0; i < m_n[d] && i < 64; i++) if (m_abs[d][i] > m) m = m_abs[d][i];
        return m;
    endfunction
    function automatic int m_first(input int d);
        for (int i = 0; i < m_n[d] && i < 64; i++) if (m_abs[d][i] > TOL) return i;
        return 0;
    endfunction
    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_ph[d] = 0; m_n[d] = 0; m_to[d] = 0; m_pass[d] = 0; m_last[d] = cyc;
            end else if (m_ph[d] != 1 && start) begin
                m_ph[d] = 1; m_n[d] = 0; m_to[d] = 0; m_pass[d] = 0; m_last[d] = cyc;
            end else if (m_ph[d] == 1 && valid) begin
                int diff;
                diff = int'($signed(din)) - int'($signed(tbl[m_n[d]]));
                m_abs[d][m_n[d]] = diff < 0 ? -diff : diff;
                m_n[d]++;
                m_last[d] = cyc;
                if (m_n[d] == 64) begin
                    m_ph[d] = 2;
                    m_pass[d] = m_errs(d) == 0;
                end
            end else if (m_ph[d] == 1 && tmo[d] != 0 && cyc - m_last[d] == tmo[d] + 1) begin
                m_ph[d] = 2; m_to[d] = 1; m_pass[d] = 0;
            end
        end
    end
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic cmp(input int d, input logic [5:0] addr, input logic busy, input logic done,
                       input logic pass, input logic to, input logic [6:0] ec,
                       input logic [16:0] me, input logic [5:0] fi);
        string p;
        p = d == 0 ? "A" : "B";
        chk({p, ".exp_addr"}, addr, m_n[d] % 64);
        chk({p, ".busy"}, busy, m_ph[d] == 1);
        chk({p, ".done"}, done, m_ph[d] == 2);
        chk({p, ".pass"}, pass, m_pass[d]);
        chk({p, ".timed_out"}, to, m_to[d]);
        chk({p, ".err_cnt"}, ec, m_errs(d));
        chk({p, ".max_err"}, me, m_max(d));
        chk({p, ".first_err_idx"}, fi, m_first(d));
    endtask
    always @(negedge clk) if (go) begin
        cmp(0, ia.exp_addr, ia.busy, ia.done, ia.pass, ia.timed_out, ia.err_cnt, ia.max_err, ia.first_err_idx);
        cmp(1, ib.exp_addr, ib.busy, ib.done, ib.pass, ib.timed_out, ib.err_cnt, ib.max_err, ib.first_err_idx);
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic send(input logic [15:0] v);
        valid = 1'b1; din = v;
        tick();
        valid = 1'b0;
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        do_reset();
        go = 1'b1;
        chk("tbl[1]", tbl[1], 16'h0C8B);
        chk("tbl[40]", tbl[40], 16'hA57E);
        chk("tbl[63]", tbl[63], 16'hF375);
        chk("reset.done", ia.done, 0);
        chk("reset.max_err", ia.max_err, 0);
        // exact table: clean pass
        pulse_start();
        chk("t1.busy", ia.busy, 1);
        for (int i = 0; i < 64; i++) send(tbl[i]);
        chk("t1.done", ia.done, 1);
        chk("t1.pass", ia.pass, 1);
        chk("t1.err_cnt", ia.err_cnt, 0);
        chk("t1.max_err", ia.max_err, 0);
        // +5 at index 10 fails, -4 at index 40 is within tolerance
        do_reset();
        pulse_start();
        for (int i = 0; i < 64; i++) send(i == 10 ? tbl[i] + 16'd5 : i == 40 ? tbl[i] - 16'd4 : tbl[i]);
        chk("t2.pass", ia.pass, 0);
        chk("t2.err_cnt", ia.err_cnt, 1);
        chk("t2.first", ia.first_err_idx, 10);
        chk("t2.max_err", ia.max_err, 5);
        // full-scale opposite sign
        do_reset();
        pulse_start();
        for (int i = 0; i < 64; i++) send(i == 48 ? 16'h7FFF : tbl[i]);
        chk("t3.max_err", ia.max_err, 65534);
        chk("t3.err_cnt", ia.err_cnt, 1);
        chk("t3.first", ia.first_err_idx, 48);
        chk("t3.pass", ia.pass, 0);
        // gapped stream
        do_reset();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            int g;
            send(tbl[i]);
            g = $urandom_range(0, 20);
            for (int j = 0; j < g; j++) tick();
            if (i < 63 && g > 0) chk("t4.addr_hold", ia.exp_addr, i + 1);
        end
        chk("t4.pass", ia.pass, 1);
        chk("t4.err_cnt", ia.err_cnt, 0);
        // timeout on B after 30 samples
        do_reset();
        pulse_start();
        for (int i = 0; i < 30; i++) send(tbl[i]);
        for (int j = 0; j < 16; j++) tick();
        chk("t5.done_early", ib.done, 0);
        tick();
        chk("t5.done", ib.done, 1);
        chk("t5.timed_out", ib.timed_out, 1);
        chk("t5.pass", ib.pass, 0);
        pulse_start();
        chk("t5.restart_done", ib.done, 0);
        chk("t5.restart_busy", ib.busy, 1);
        chk("t5.a_ignore_start", ia.exp_addr, 30);
        for (int i = 0; i < 64; i++) send(tbl[i]);
        chk("t5.rerun_pass", ib.pass, 1);
        chk("t5.rerun_to", ib.timed_out, 0);
        // idle valids ignored, then reset mid-capture
        do_reset();
        for (int i = 0; i < 3; i++) send(16'h1234);
        chk("t6.idle_err", ia.err_cnt, 0);
        chk("t6.idle_max", ia.max_err, 0);
        chk("t6.idle_busy", ia.busy, 0);
        pulse_start();
        for (int i = 0; i < 20; i++) send(i == 5 ? tbl[i] + 16'd9 : tbl[i]);
        chk("t6.pre_err", ia.err_cnt, 1);
        chk("t6.pre_addr", ia.exp_addr, 20);
        do_reset();
        chk("t6.rst_busy", ia.busy, 0);
        chk("t6.rst_addr", ia.exp_addr, 0);
        chk("t6.rst_err", ia.err_cnt, 0);
        chk("t6.rst_max", ia.max_err, 0);
        chk("t6.rst_first", ia.first_err_idx, 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
